// File: rtl/dma_chan_regfile.sv
// Register file for an 8237-class DMA controller. It holds the per-channel address, count and mode
// registers plus the shared control/status registers, and applies per-transfer updates including terminal count.
module dma_chan_regfile #(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 16,
  parameter int COUNT_W = 16
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [3:0]                 a,
  input  logic [7:0]                 din,
  output logic [7:0]                 dout,
  input  logic                       upd_en,
  input  logic [1:0]                 upd_ch,
  input  logic                       eop_in,
  input  logic [NUM_CH-1:0]          dreq,
  output logic [8*NUM_CH-1:0]        mode_o,
  output logic [7:0]                 command_o,
  output logic [NUM_CH-1:0]          request_o,
  output logic [NUM_CH-1:0]          mask_o,
  output logic [NUM_CH-1:0]          tc_o,
  output logic [ADDR_W*NUM_CH-1:0]   cur_addr_o,
  output logic [COUNT_W*NUM_CH-1:0]  cur_count_o
);

  localparam logic [1:0] ADDR_LAST  = 2'(ADDR_W / 8 - 1);
  localparam logic [1:0] COUNT_LAST = 2'(COUNT_W / 8 - 1);

  logic [7:0]         modeR [NUM_CH];
  logic [7:0]         modeN [NUM_CH];
  logic [ADDR_W-1:0]  baseAddrR [NUM_CH];
  logic [ADDR_W-1:0]  baseAddrN [NUM_CH];
  logic [ADDR_W-1:0]  curAddrR [NUM_CH];
  logic [ADDR_W-1:0]  curAddrN [NUM_CH];
  logic [COUNT_W-1:0] baseCountR [NUM_CH];
  logic [COUNT_W-1:0] baseCountN [NUM_CH];
  logic [COUNT_W-1:0] curCountR [NUM_CH];
  logic [COUNT_W-1:0] curCountN [NUM_CH];
  logic [7:0]         commandR, commandN;
  logic [NUM_CH-1:0]  requestR, requestN, maskR, maskN, tcR, tcN;
  logic [1:0]         bpR, bpN, bpLast, bpAdv;
  logic [7:0]         doutR, doutN;
  logic [7:0]         statusByte, readByte;
  logic               rdOnly, chHit, updTc;

  function automatic logic [7:0] getAddrByte(input logic [ADDR_W-1:0] v, input logic [1:0] idx);
    return 8'(v >> (8 * idx));
  endfunction

  function automatic logic [7:0] getCountByte(input logic [COUNT_W-1:0] v, input logic [1:0] idx);
    return 8'(v >> (8 * idx));
  endfunction

  function automatic logic [ADDR_W-1:0] setAddrByte(input logic [ADDR_W-1:0] v, input logic [1:0] idx,
                                                   input logic [7:0] b);
    return (v & ~(ADDR_W'(8'hFF) << (8 * idx))) | (ADDR_W'(b) << (8 * idx));
  endfunction

  function automatic logic [COUNT_W-1:0] setCountByte(input logic [COUNT_W-1:0] v, input logic [1:0] idx,
                                                     input logic [7:0] b);
    return (v & ~(COUNT_W'(8'hFF) << (8 * idx))) | (COUNT_W'(b) << (8 * idx));
  endfunction

  assign rdOnly = rd_en & ~wr_en;
  assign bpLast = a[0] ? COUNT_LAST : ADDR_LAST;
  assign bpAdv  = (bpR == bpLast) ? 2'd0 : bpR + 2'd1;

  always_comb begin
    statusByte = '0;
    readByte   = '0;
    chHit      = 1'b0;
    for (int n = 0; n < NUM_CH; n++) begin
      statusByte[4+n] = dreq[n] | requestR[n];
      statusByte[n]   = tcR[n];
      if (a[2:1] == 2'(n)) begin
        chHit = 1'b1;
        if (!a[3])
          readByte = a[0] ? getCountByte(curCountR[n], bpR) : getAddrByte(curAddrR[n], bpR);
      end
    end
    if (a[3] && a[2:0] == 3'd0)
      readByte = statusByte;
  end

  // Next-state: CPU control writes, then status-read clear, then transfer update (TC wins),
  // then CPU channel byte writes (CPU wins over the transfer for that register).
  always_comb begin
    modeN      = modeR;
    baseAddrN  = baseAddrR;
    curAddrN   = curAddrR;
    baseCountN = baseCountR;
    curCountN  = curCountR;
    commandN   = commandR;
    requestN   = requestR;
    maskN      = maskR;
    tcN        = tcR;
    bpN        = bpR;
    updTc      = 1'b0;
    doutN      = rdOnly ? readByte : doutR;

    if (wr_en && a[3]) begin
      case (a[2:0])
        3'd0: commandN = din;
        3'd1: for (int n = 0; n < NUM_CH; n++) if (din[1:0] == 2'(n)) requestN[n] = din[2];
        3'd2: for (int n = 0; n < NUM_CH; n++) if (din[1:0] == 2'(n)) maskN[n] = din[2];
        3'd3: for (int n = 0; n < NUM_CH; n++) if (din[1:0] == 2'(n)) modeN[n] = din;
        3'd4: bpN = 2'd0;
        3'd5: begin
          commandN = '0;
          requestN = '0;
          tcN      = '0;
          maskN    = '1;
          bpN      = 2'd0;
          doutN    = '0;
        end
        3'd6: maskN = '0;
        default: maskN = din[NUM_CH-1:0];
      endcase
    end

    if (rdOnly && a == 4'h8)
      tcN = '0;

    if ((wr_en || rd_en) && !a[3] && chHit)
      bpN = bpAdv;

    for (int n = 0; n < NUM_CH; n++) begin
      if (upd_en && upd_ch == 2'(n)) begin
        updTc = (curCountR[n] == '0) || eop_in;
        if (updTc) begin
          tcN[n]      = 1'b1;
          requestN[n] = 1'b0;
        end
        if (updTc && modeR[n][4]) begin
          curAddrN[n]  = baseAddrR[n];
          curCountN[n] = baseCountR[n];
        end else begin
          if (updTc)
            maskN[n] = 1'b1;
          curCountN[n] = curCountR[n] - COUNT_W'(1);
          curAddrN[n]  = modeR[n][5] ? curAddrR[n] - ADDR_W'(1) : curAddrR[n] + ADDR_W'(1);
        end
      end
    end

    if (wr_en && !a[3]) begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (a[2:1] == 2'(n)) begin
          if (a[0]) begin
            baseCountN[n] = setCountByte(baseCountR[n], bpR, din);
            curCountN[n]  = setCountByte(curCountR[n], bpR, din);
          end else begin
            baseAddrN[n] = setAddrByte(baseAddrR[n], bpR, din);
            curAddrN[n]  = setAddrByte(curAddrR[n], bpR, din);
          end
        end
      end
    end
  end

  // State register stage
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int n = 0; n < NUM_CH; n++) begin
        modeR[n]      <= '0;
        baseAddrR[n]  <= '0;
        curAddrR[n]   <= '0;
        baseCountR[n] <= '0;
        curCountR[n]  <= '0;
      end
      commandR <= '0;
      requestR <= '0;
      maskR    <= '1;
      tcR      <= '0;
      bpR      <= 2'd0;
      doutR    <= '0;
    end else begin
      modeR      <= modeN;
      baseAddrR  <= baseAddrN;
      curAddrR   <= curAddrN;
      baseCountR <= baseCountN;
      curCountR  <= curCountN;
      commandR   <= commandN;
      requestR   <= requestN;
      maskR      <= maskN;
      tcR        <= tcN;
      bpR        <= bpN;
      doutR      <= doutN;
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : gOut
    assign mode_o[8*n +: 8]                = modeR[n];
    assign cur_addr_o[ADDR_W*n +: ADDR_W]  = curAddrR[n];
    assign cur_count_o[COUNT_W*n +: COUNT_W] = curCountR[n];
  end

  assign dout      = doutR;
  assign command_o = commandR;
  assign request_o = requestR;
  assign mask_o    = maskR;
  assign tc_o      = tcR;

endmodule

// File: tb/tb_dma_chan_regfile.sv
// Directed bench for dma_chan_regfile: a default 16-bit instance plus a 24-bit-address instance
// driven from the same CPU/transfer inputs.
module tb_dma_chan_regfile;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0, upd_en = 1'b0, eop_in = 1'b0;
  logic [3:0]  a = '0;
  logic [7:0]  din = '0;
  logic [1:0]  upd_ch = '0;
  logic [3:0]  dreq = '0;

  logic [7:0]  dout, dout24;
  logic [31:0] mode_o, mode24;
  logic [7:0]  command_o, command24;
  logic [3:0]  request_o, mask_o, tc_o, request24, mask24, tc24;
  logic [63:0] cur_addr_o, cur_count_o, count24;
  logic [95:0] addr24;

  int nCmp = 0;
  int nFail = 0;

  always #5 CLK = ~CLK;

  dma_chan_regfile #(.NUM_CH(4), .ADDR_W(16), .COUNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .wr_en(wr_en), .rd_en(rd_en), .a(a), .din(din), .dout(dout),
    .upd_en(upd_en), .upd_ch(upd_ch), .eop_in(eop_in), .dreq(dreq), .mode_o(mode_o),
    .command_o(command_o), .request_o(request_o), .mask_o(mask_o), .tc_o(tc_o),
    .cur_addr_o(cur_addr_o), .cur_count_o(cur_count_o));

  dma_chan_regfile #(.NUM_CH(4), .ADDR_W(24), .COUNT_W(16)) dut24 (
    .CLK(CLK), .RESET(RESET), .wr_en(wr_en), .rd_en(rd_en), .a(a), .din(din), .dout(dout24),
    .upd_en(upd_en), .upd_ch(upd_ch), .eop_in(eop_in), .dreq(dreq), .mode_o(mode24),
    .command_o(command24), .request_o(request24), .mask_o(mask24), .tc_o(tc24),
    .cur_addr_o(addr24), .cur_count_o(count24));

  task automatic wrByte(input logic [3:0] addr, input logic [7:0] d);
    a = addr; din = d; wr_en = 1'b1;
    @(posedge CLK); #1;
    wr_en = 1'b0;
  endtask

  task automatic rdByte(input logic [3:0] addr);
    a = addr; rd_en = 1'b1;
    @(posedge CLK); #1;
    rd_en = 1'b0;
  endtask

  task automatic upd(input logic [1:0] c, input logic e);
    upd_ch = c; eop_in = e; upd_en = 1'b1;
    @(posedge CLK); #1;
    upd_en = 1'b0; eop_in = 1'b0;
  endtask

  task automatic test_reset;
    RESET = 1'b0; wr_en = 1'b1; rd_en = 1'b1; upd_en = 1'b1; eop_in = 1'b1; a = 4'h0; din = 8'hFF;
    repeat (2) @(posedge CLK);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; upd_en = 1'b0; eop_in = 1'b0;
    nCmp++; if (mask_o !== 4'hF) begin nFail++; $display("FAIL reset_mask: got %h want %h", mask_o, 4'hF); end
    nCmp++; if (command_o !== 8'h00) begin nFail++; $display("FAIL reset_command: got %h want 00", command_o); end
    nCmp++; if (request_o !== 4'h0 || tc_o !== 4'h0) begin nFail++; $display("FAIL reset_req_tc: got %h/%h want 0/0", request_o, tc_o); end
    nCmp++; if (mode_o !== 32'h0) begin nFail++; $display("FAIL reset_mode: got %h want 0", mode_o); end
    nCmp++; if (cur_addr_o !== 64'h0 || cur_count_o !== 64'h0) begin nFail++; $display("FAIL reset_addr_count: got %h/%h want 0/0", cur_addr_o, cur_count_o); end
    nCmp++; if (dout !== 8'h00) begin nFail++; $display("FAIL reset_dout: got %h want 00", dout); end
    nCmp++; if (mask24 !== 4'hF || addr24 !== 96'h0) begin nFail++; $display("FAIL reset_dut24: got %h/%h want F/0", mask24, addr24); end
    RESET = 1'b1;
    rdByte(4'h8);
    nCmp++; if (dout !== 8'h00) begin nFail++; $display("FAIL reset_status: got %h want 00", dout); end
  endtask

  task automatic test_chan_bytes;
    wrByte(4'h2, 8'h34); wrByte(4'h2, 8'h12);
    nCmp++; if (cur_addr_o[31:16] !== 16'h1234) begin nFail++; $display("FAIL addr_ch1: got %h want 1234", cur_addr_o[31:16]); end
    wrByte(4'h3, 8'h02); wrByte(4'h3, 8'h00);
    nCmp++; if (cur_count_o[31:16] !== 16'h0002) begin nFail++; $display("FAIL count_ch1: got %h want 0002", cur_count_o[31:16]); end
    rdByte(4'h2);
    nCmp++; if (dout !== 8'h34) begin nFail++; $display("FAIL read_lo: got %h want 34", dout); end
    rdByte(4'h2);
    nCmp++; if (dout !== 8'h12) begin nFail++; $display("FAIL read_hi: got %h want 12", dout); end
    wrByte(4'h2, 8'hAA);
    nCmp++; if (cur_addr_o[31:16] !== 16'h12AA) begin nFail++; $display("FAIL partial_write: got %h want 12AA", cur_addr_o[31:16]); end
    wrByte(4'hC, 8'h00);
    wrByte(4'h2, 8'h34); wrByte(4'h2, 8'h12);
    nCmp++; if (cur_addr_o[31:16] !== 16'h1234) begin nFail++; $display("FAIL bp_clear_restart: got %h want 1234", cur_addr_o[31:16]); end
  endtask

  task automatic test_incr_tc;
    wrByte(4'hE, 8'h00);
    wrByte(4'hB, 8'h05);
    nCmp++; if (mode_o[15:8] !== 8'h05 || mask_o !== 4'h0) begin nFail++; $display("FAIL mode_ch1: got %h/%h want 05/0", mode_o[15:8], mask_o); end
    upd(2'd1, 1'b0);
    nCmp++; if (cur_count_o[31:16] !== 16'h0001 || cur_addr_o[31:16] !== 16'h1235) begin nFail++; $display("FAIL upd1: got %h/%h want 0001/1235", cur_count_o[31:16], cur_addr_o[31:16]); end
    upd(2'd1, 1'b0);
    nCmp++; if (cur_count_o[31:16] !== 16'h0000 || cur_addr_o[31:16] !== 16'h1236 || tc_o !== 4'h0) begin nFail++; $display("FAIL upd2: got %h/%h tc %h want 0000/1236 tc 0", cur_count_o[31:16], cur_addr_o[31:16], tc_o); end
    upd(2'd1, 1'b0);
    nCmp++; if (cur_count_o[31:16] !== 16'hFFFF || cur_addr_o[31:16] !== 16'h1237) begin nFail++; $display("FAIL upd3: got %h/%h want FFFF/1237", cur_count_o[31:16], cur_addr_o[31:16]); end
    nCmp++; if (tc_o !== 4'h2 || mask_o !== 4'h2) begin nFail++; $display("FAIL tc_mask_ch1: got %h/%h want 2/2", tc_o, mask_o); end
    rdByte(4'h8);
    nCmp++; if (dout !== 8'h02) begin nFail++; $display("FAIL status_tc: got %h want 02", dout); end
    rdByte(4'h8);
    nCmp++; if (dout !== 8'h00) begin nFail++; $display("FAIL status_cleared: got %h want 00", dout); end
  endtask

  task automatic test_autoinit;
    wrByte(4'hB, 8'h34);
    wrByte(4'h0, 8'h00); wrByte(4'h0, 8'h01);
    wrByte(4'h1, 8'h00); wrByte(4'h1, 8'h00);
    upd(2'd0, 1'b0);
    nCmp++; if (cur_addr_o[15:0] !== 16'h0100 || cur_count_o[15:0] !== 16'h0000) begin nFail++; $display("FAIL autoinit_reload: got %h/%h want 0100/0000", cur_addr_o[15:0], cur_count_o[15:0]); end
    nCmp++; if (tc_o !== 4'h1 || mask_o !== 4'h2) begin nFail++; $display("FAIL autoinit_tc_mask: got %h/%h want 1/2", tc_o, mask_o); end
    wrByte(4'h1, 8'h03); wrByte(4'h1, 8'h00);
    upd(2'd0, 1'b0);
    nCmp++; if (cur_addr_o[15:0] !== 16'h00FF || cur_count_o[15:0] !== 16'h0002) begin nFail++; $display("FAIL decrement: got %h/%h want 00FF/0002", cur_addr_o[15:0], cur_count_o[15:0]); end
  endtask

  task automatic test_addr24;
    RESET = 1'b0; @(posedge CLK); #1; RESET = 1'b1;
    wrByte(4'hE, 8'h00);
    wrByte(4'h0, 8'h56); wrByte(4'h0, 8'h34); wrByte(4'h0, 8'h12);
    nCmp++; if (addr24[23:0] !== 24'h123456) begin nFail++; $display("FAIL addr24_bytes: got %h want 123456", addr24[23:0]); end
    wrByte(4'h0, 8'h99);
    nCmp++; if (addr24[23:0] !== 24'h123499) begin nFail++; $display("FAIL addr24_wrap: got %h want 123499", addr24[23:0]); end
    wrByte(4'hC, 8'h00);
    wrByte(4'h1, 8'h05); wrByte(4'h1, 8'h00);
    wrByte(4'hB, 8'h00);
    upd(2'd0, 1'b1);
    nCmp++; if (tc24 !== 4'h1 || mask24 !== 4'h1) begin nFail++; $display("FAIL eop_tc: got %h/%h want 1/1", tc24, mask24); end
    nCmp++; if (count24[15:0] !== 16'h0004 || addr24[23:0] !== 24'h12349A) begin nFail++; $display("FAIL eop_update: got %h/%h want 0004/12349A", count24[15:0], addr24[23:0]); end
  endtask

  task automatic test_same_cycle;
    wrByte(4'h9, 8'h06);
    nCmp++; if (request_o !== 4'h4) begin nFail++; $display("FAIL request_set: got %h want 4", request_o); end
    a = 4'h8; rd_en = 1'b1; upd_ch = 2'd2; upd_en = 1'b1;
    @(posedge CLK); #1;
    rd_en = 1'b0; upd_en = 1'b0;
    nCmp++; if (dout !== 8'h41) begin nFail++; $display("FAIL status_pre: got %h want 41", dout); end
    nCmp++; if (tc_o !== 4'h4 || request_o !== 4'h0 || mask_o !== 4'h5) begin nFail++; $display("FAIL tc_wins: got tc %h req %h mask %h want 4/0/5", tc_o, request_o, mask_o); end
    rdByte(4'h8);
    nCmp++; if (dout !== 8'h04) begin nFail++; $display("FAIL status_ch2: got %h want 04", dout); end
    rdByte(4'h8);
    nCmp++; if (dout !== 8'h00) begin nFail++; $display("FAIL status_ch2_clr: got %h want 00", dout); end
  endtask

  task automatic test_control;
    dreq = 4'b1000;
    rdByte(4'h8);
    nCmp++; if (dout !== 8'h80) begin nFail++; $display("FAIL status_dreq: got %h want 80", dout); end
    a = 4'h8; din = 8'h5A; wr_en = 1'b1; rd_en = 1'b1;
    @(posedge CLK); #1;
    wr_en = 1'b0; rd_en = 1'b0; dreq = 4'b0000;
    nCmp++; if (command_o !== 8'h5A || dout !== 8'h80) begin nFail++; $display("FAIL wr_rd_together: got %h/%h want 5A/80", command_o, dout); end
    rdByte(4'hB);
    nCmp++; if (dout !== 8'h00) begin nFail++; $display("FAIL ctl_read_zero: got %h want 00", dout); end
    wrByte(4'hB, 8'hC7);
    upd(2'd3, 1'b1);
    nCmp++; if (mode_o[31:24] !== 8'hC7 || tc_o !== 4'h8) begin nFail++; $display("FAIL mode_ch3_tc: got %h/%h want C7/8", mode_o[31:24], tc_o); end
    wrByte(4'hD, 8'h00);
    nCmp++; if (command_o !== 8'h00 || mask_o !== 4'hF || tc_o !== 4'h0 || request_o !== 4'h0) begin nFail++; $display("FAIL master_clear: got cmd %h mask %h tc %h req %h want 00/F/0/0", command_o, mask_o, tc_o, request_o); end
    nCmp++; if (mode_o[31:24] !== 8'hC7 || cur_count_o[15:0] !== 16'h0004) begin nFail++; $display("FAIL master_clear_keep: got %h/%h want C7/0004", mode_o[31:24], cur_count_o[15:0]); end
  endtask

  initial begin
    test_reset();
    test_chan_bytes();
    test_incr_tc();
    test_autoinit();
    test_addr24();
    test_same_cycle();
    test_control();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
